// File: rtl/chan_mux_rr.sv
// chan_mux_rr
// Selects one of CHANNELS source words, either by an explicit select index or by
// round-robin arbitration, and presents it through a one-entry output register
// with a valid/ready handshake.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   mode       0 = fixed select via sel, 1 = round-robin
//   sel        channel index used in mode 0
//   in_data    packed channel words, channel k at [k*WIDTH +: WIDTH]
//   in_valid   per-channel valid
//   in_ready   per-channel ready, at most one bit high
//   out_data   registered selected word
//   out_chan   index of the channel that supplied out_data
//   out_valid  output register holds a word
//   out_ready  consumer accepts the word this cycle
module chan_mux_rr #(
  parameter int WIDTH    = 32,
  parameter int CHANNELS = 4,
  parameter int SEL_W    = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      mode,
  input  logic [SEL_W-1:0]          sel,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [CHANNELS-1:0]       in_valid,
  output logic [CHANNELS-1:0]       in_ready,
  output logic [WIDTH-1:0]          out_data,
  output logic [SEL_W-1:0]          out_chan,
  output logic                      out_valid,
  input  logic                      out_ready
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   data_q, data_d;
  logic [SEL_W-1:0]   chan_q, chan_d;
  logic [SEL_W-1:0]   ptr_q, ptr_d;

  logic               load;
  logic               grant;
  logic               xfer;
  logic [SEL_W-1:0]   gidx;
  logic [SEL_W-1:0]   cand;
  logic [WIDTH-1:0]   g_word;

  assign out_valid = (state_q == FULL);
  assign out_data  = data_q;
  assign out_chan  = chan_q;

  // The register can take a new word when it is empty or being drained now.
  assign load = ~out_valid | out_ready;

  // Grant selection. In fixed mode an out-of-range sel matches no channel, so it
  // can never grant. In round-robin mode the search starts one past the last
  // granted channel and wraps modulo CHANNELS; the first valid channel wins.
  always_comb begin
    grant = 1'b0;
    gidx  = '0;
    cand  = '0;
    if (!mode) begin
      for (int k = 0; k < CHANNELS; k++) begin
        if (sel == SEL_W'(k) && in_valid[k]) begin
          grant = 1'b1;
          gidx  = SEL_W'(k);
        end
      end
    end else begin
      for (int off = 1; off <= CHANNELS; off++) begin
        cand = SEL_W'((int'(ptr_q) + off) % CHANNELS);
        if (!grant && in_valid[cand]) begin
          grant = 1'b1;
          gidx  = cand;
        end
      end
    end
  end

  // Word of the granted channel; only feeds the data register, so in_data
  // never reaches an output combinationally.
  always_comb begin
    g_word = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (gidx == SEL_W'(k)) begin
        g_word = in_data[k*WIDTH +: WIDTH];
      end
    end
  end

  // One-hot ready towards the granted source; held low while reset is asserted.
  always_comb begin
    in_ready = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      in_ready[k] = ~rst & load & grant & (gidx == SEL_W'(k));
    end
  end

  assign xfer = ~rst & load & grant;

  // Next-state of the output register and round-robin pointer. A transfer
  // always fills the register (replacing a word drained on the same edge);
  // a drain with nothing granted empties it but leaves the stale data/chan.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    chan_d  = chan_q;
    ptr_d   = ptr_q;
    if (xfer) begin
      state_d = FULL;
      data_d  = g_word;
      chan_d  = gidx;
      if (mode) begin
        ptr_d = gidx;
      end
    end else if (state_q == FULL && out_ready) begin
      state_d = EMPTY;
    end
  end

  // Pointer resets to the last channel so the first round-robin search
  // begins at channel 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= EMPTY;
      data_q  <= '0;
      chan_q  <= '0;
      ptr_q   <= SEL_W'(CHANNELS - 1);
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      chan_q  <= chan_d;
      ptr_q   <= ptr_d;
    end
  end

endmodule

// File: tb/tb_chan_mux_rr.sv
// tb_chan_mux_rr
// Directed bench for chan_mux_rr. Stimulus pushes the expected {chan, data} of
// every accepted word into a scoreboard queue; a monitor pops and compares each
// time the DUT hands a word to the consumer (out_valid & out_ready).
// A second instance with CHANNELS = 3 covers the out-of-range select case.
module tb_chan_mux_rr;

  logic         clk;
  logic         rst;
  logic         mode;
  logic [1:0]   sel;
  logic [127:0] in_data;
  logic [3:0]   in_valid;
  logic [3:0]   in_ready;
  logic [31:0]  out_data;
  logic [1:0]   out_chan;
  logic         out_valid;
  logic         out_ready;

  logic         mode3;
  logic [1:0]   sel3;
  logic [95:0]  in_data3;
  logic [2:0]   in_valid3;
  logic [2:0]   in_ready3;
  logic [31:0]  out_data3;
  logic [1:0]   out_chan3;
  logic         out_valid3;
  logic         out_ready3;

  int checks;
  int failures;
  logic [33:0] exp_q [$];

  localparam logic [127:0] W_RR  = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
  localparam logic [127:0] W_T1  = {32'h00000000, 32'hDEADBEEF, 32'h00000000, 32'h00000000};
  localparam logic [127:0] W_55  = {96'h0, 32'h00000055};
  localparam logic [127:0] W_AA  = {96'h0, 32'h000000AA};
  localparam logic [127:0] W_77  = {64'h0, 32'h00000077, 32'h00000000};

  chan_mux_rr #(.WIDTH(32), .CHANNELS(4), .SEL_W(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .mode      (mode),
    .sel       (sel),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_chan  (out_chan),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  chan_mux_rr #(.WIDTH(32), .CHANNELS(3), .SEL_W(2)) dut3 (
    .clk       (clk),
    .rst       (rst),
    .mode      (mode3),
    .sel       (sel3),
    .in_data   (in_data3),
    .in_valid  (in_valid3),
    .in_ready  (in_ready3),
    .out_data  (out_data3),
    .out_chan  (out_chan3),
    .out_valid (out_valid3),
    .out_ready (out_ready3)
  );

  // 10-unit clock period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Single comparison point; every check steps the counters here.
  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%08h expected=0x%08h", name, actual, expected);
    end
  endtask

  // Drive one cycle of inputs just after the rising edge, then check in_ready at
  // the falling edge. exp_g is the hand-computed granted channel (-1 for none);
  // when do_push is set the word that will be captured goes into the scoreboard.
  task automatic applyStimulus(input logic m, input logic [1:0] s, input logic [3:0] v,
                               input logic rdy, input logic [127:0] words,
                               input int exp_g, input bit do_push, input string name);
    logic [3:0] exp_ready;
    @(posedge clk);
    #1;
    mode      = m;
    sel       = s;
    in_valid  = v;
    out_ready = rdy;
    in_data   = words;
    exp_ready = (exp_g < 0) ? 4'b0000 : 4'(1 << exp_g);
    @(negedge clk);
    checkOutput(name, {28'h0, in_ready}, {28'h0, exp_ready});
    if (exp_g >= 0 && do_push) begin
      exp_q.push_back({2'(exp_g), words[exp_g*32 +: 32]});
    end
  endtask

  // Monitor: each word consumed by the downstream side is checked in order.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL unexpected_word actual=chan %0d data 0x%08h expected=none", out_chan, out_data);
      end else begin
        logic [33:0] e;
        e = exp_q.pop_front();
        checkOutput("sb_chan", {30'h0, out_chan}, {30'h0, e[33:32]});
        checkOutput("sb_data", out_data, e[31:0]);
      end
    end
  end

  // Absolute time limit so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    checks     = 0;
    failures   = 0;
    rst        = 1'b1;
    mode       = 1'b1;
    sel        = 2'd0;
    in_valid   = 4'b1111;
    in_data    = W_RR;
    out_ready  = 1'b0;
    mode3      = 1'b0;
    sel3       = 2'd3;
    in_valid3  = 3'b111;
    in_data3   = {32'h33333333, 32'h22222222, 32'h11111111};
    out_ready3 = 1'b1;

    // Reset state, with a grantable request pending to prove ready is gated.
    #2;
    checkOutput("rst_out_valid", {31'h0, out_valid}, 32'h0);
    checkOutput("rst_out_data", out_data, 32'h0);
    checkOutput("rst_out_chan", {30'h0, out_chan}, 32'h0);
    checkOutput("rst_in_ready", {28'h0, in_ready}, 32'h0);
    #9;
    in_valid = 4'b0000;
    #1;
    rst = 1'b0;

    // Out-of-range select on the 3-channel instance never grants.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checkOutput("oor_in_ready", {29'h0, in_ready3}, 32'h0);
      checkOutput("oor_out_valid", {31'h0, out_valid3}, 32'h0);
    end

    // Fixed select on channel 2, then an invalid channel 3 drains the register.
    applyStimulus(1'b0, 2'd2, 4'b0100, 1'b1, W_T1, 2, 1'b1, "m0_sel2");
    applyStimulus(1'b0, 2'd3, 4'b0000, 1'b1, W_T1, -1, 1'b0, "m0_sel3_none");
    applyStimulus(1'b0, 2'd3, 4'b0000, 1'b1, W_T1, -1, 1'b0, "m0_idle");
    checkOutput("m0_out_valid_fall", {31'h0, out_valid}, 32'h0);

    // Round-robin fairness from the reset pointer: 0,1,2,3,0,1.
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b1, 2'd0, 4'b1111, 1'b1, W_RR, i % 4, 1'b1, "rr_fair");
    end

    // Move the pointer to 3, then channels 1 and 3 alternate: 1,3,1,3.
    applyStimulus(1'b1, 2'd0, 4'b1000, 1'b1, W_RR, 3, 1'b1, "rr_set_ptr");
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 2'd0, 4'b1010, 1'b1, W_RR, (i % 2 == 0) ? 1 : 3, 1'b1, "rr_wrap");
    end
    applyStimulus(1'b1, 2'd0, 4'b0000, 1'b1, W_RR, -1, 1'b0, "rr_idle");

    // Backpressure: hold 0x55 for three stalled cycles, then drain and load 0xAA.
    applyStimulus(1'b0, 2'd0, 4'b0001, 1'b1, W_55, 0, 1'b1, "bp_load");
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 2'd0, 4'b0001, 1'b0, W_AA, -1, 1'b0, "bp_stall");
      checkOutput("bp_hold_data", out_data, 32'h00000055);
      checkOutput("bp_hold_valid", {31'h0, out_valid}, 32'h1);
    end
    applyStimulus(1'b0, 2'd0, 4'b0001, 1'b1, W_AA, 0, 1'b1, "bp_drain_load");
    applyStimulus(1'b0, 2'd0, 4'b0000, 1'b1, W_AA, -1, 1'b0, "bp_idle");
    checkOutput("bp_new_data", out_data, 32'h000000AA);

    // Reset in the middle of a held word discards it; afterwards the first
    // round-robin grant goes to channel 0.
    applyStimulus(1'b0, 2'd1, 4'b0010, 1'b0, W_77, 1, 1'b0, "rst_mid_load");
    @(negedge clk);
    checkOutput("rst_mid_held_valid", {31'h0, out_valid}, 32'h1);
    checkOutput("rst_mid_held_data", out_data, 32'h00000077);
    #1;
    mode     = 1'b1;
    in_valid = 4'b1111;
    in_data  = W_RR;
    rst      = 1'b1;
    #1;
    checkOutput("rst_async_valid", {31'h0, out_valid}, 32'h0);
    checkOutput("rst_async_data", out_data, 32'h0);
    checkOutput("rst_async_chan", {30'h0, out_chan}, 32'h0);
    checkOutput("rst_async_ready", {28'h0, in_ready}, 32'h0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("post_rst_ready", {28'h0, in_ready}, 32'h1);
    out_ready = 1'b1;
    exp_q.push_back({2'd0, 32'h11111111});
    applyStimulus(1'b1, 2'd0, 4'b0000, 1'b1, W_RR, -1, 1'b0, "post_rst_idle");

    @(negedge clk);
    checkOutput("sb_empty", 32'(exp_q.size()), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/chan_mux_rr.md
# chan_mux_rr

Parametrised, registered N-channel successor to the ALU's 2:1 bit multiplexer. It selects one of CHANNELS WIDTH-bit source channels, using either an explicit select input or round-robin arbitration. The chosen word is presented through a one-entry output register with a valid/ready handshake. It sits between the ALU operand/result sources and any consumer that can stall, such as the register-file write port or the result bus.

## Interface
- WIDTH, 32, data width per channel in bits.
- CHANNELS, 4, number of source channels (2..16).
- SEL_W, 2, select/channel-index width; must satisfy 2^SEL_W >= CHANNELS.
- clk  input  1  rising-edge clock; the block uses one clock only.
- rst  input  1  reset, asynchronous and active-high; clears all state immediately.
- mode  input  1  0 = fixed select via sel, 1 = round-robin arbitration.
- sel  input  SEL_W  channel index used when mode = 0.
- in_data  input  CHANNELS*WIDTH  channel k occupies bits [k*WIDTH +: WIDTH].
- in_valid  input  CHANNELS  per-channel valid.
- in_ready  output  CHANNELS  per-channel ready; at most one bit high per cycle.
- out_data  output  WIDTH  registered selected word.
- out_chan  output  SEL_W  index of the channel that supplied out_data.
- out_valid  output  1  out_data/out_chan hold a word.
- out_ready  input  1  consumer accepts the word this cycle.

## Operation
- Storage: one output register (out_data, out_chan, out_valid) plus round-robin pointer ptr (SEL_W bits, last granted channel).
- Load enable: load = ~out_valid | out_ready. The register accepts a new word when empty or when being drained in the same cycle.
- Grant, mode 0: g = sel if sel < CHANNELS and in_valid[sel]; otherwise no grant. sel >= CHANNELS never grants and never raises any in_ready.
- Grant, mode 1: g = first k with in_valid[k], searching ptr+1, ptr+2, ... modulo CHANNELS (wrap past CHANNELS-1 to 0). If no valid channel, no grant.
- in_ready[k] = load & grant & (k == g). Transfer on channel k occurs when in_valid[k] & in_ready[k].
- On transfer: out_data <= channel g word, out_chan <= g, out_valid <= 1. In mode 1 only, ptr <= g. ptr is unchanged in mode 0.
- Drain without new transfer (out_valid & out_ready & no grant): out_valid <= 0. out_data and out_chan hold their stale values.
- Stall (out_valid & ~out_ready): all in_ready = 0; the register holds.
- Simultaneous drain and load: a new word replaces the old one in the same edge. This gives full throughput of one word per cycle.
- Mode or sel change takes effect on the next grant evaluation; it never disturbs a word already held. ptr is retained across mode switches.
- Sources must hold in_data/in_valid stable until transfer. The block does not buffer non-granted channels.
- States (out_valid): EMPTY -> FULL on transfer; FULL -> FULL on drain+transfer or stall; FULL -> EMPTY on drain with no grant.

## Timing
- Reset values (asynchronous, while rst = 1): out_valid = 0, out_data = 0, out_chan = 0, ptr = CHANNELS-1. The first round-robin search therefore starts at channel 0.
- in_ready = 0 during reset.
- Latency: one cycle from the transfer edge to out_valid/out_data visible.
- Throughput: one word per clock when out_ready is held high.
- in_ready is combinational from mode, sel, in_valid, out_valid and out_ready. There is no combinational path from in_data to any output.
- Reset asserted mid-transfer discards the held word; no in_ready is high until reset deasserts. The first transfer can occur on the first rising edge after deassertion.

## Test plan
- Reset: assert rst asynchronously between edges with out_valid = 1 -> out_valid, out_data and out_chan go to 0 immediately; the post-reset mode 1 grant with all in_valid = 1 goes to channel 0.
- Mode 0, WIDTH 32, CHANNELS 4: sel = 2, channel 2 = 0xDEADBEEF valid, out_ready = 1 -> in_ready = 0100; next cycle out_data = 0xDEADBEEF, out_chan = 2. Then sel = 3 with in_valid[3] = 0 -> no grant, out_valid falls.
- Round-robin fairness: all four channels valid continuously, out_ready = 1 -> out_chan sequence 0,1,2,3,0,1 on consecutive cycles; in_ready is one-hot each cycle.
- Wrap and skip: ptr = 3, only channels 1 and 3 valid -> grant order 1,3,1,3.
- Backpressure: out_valid = 1 with 0x00000055, out_ready = 0 for 3 cycles -> all in_ready = 0 and out_data stays 0x00000055. On the cycle out_ready = 1 with channel 0 valid (0x000000AA) -> drain and load in the same edge, out_data = 0x000000AA.
- Out-of-range select, CHANNELS = 3, SEL_W = 2: mode 0, sel = 3, all valid -> in_ready = 000 indefinitely and out_valid stays 0.
